// File: rtl/rx_pkg.sv
// Shared definitions for the UART receive command path: command bytes, FSM
// states and the bit positions of the one-hot operation enables.
package rx_pkg;

  localparam logic [7:0] CMD_LOAD_A = 8'h01;
  localparam logic [7:0] CMD_LOAD_B = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_SUM    = 8'h04;
  localparam logic [7:0] CMD_AVG    = 8'h05;
  localparam logic [7:0] CMD_EUC    = 8'h06;
  localparam logic [7:0] CMD_MAN    = 8'h07;
  localparam logic [7:0] CMD_DOT    = 8'h08;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FINISH
  } rx_state_t;

  // Same bit order as the transmit controller: {dot, man, euc, avg, sum, read}
  localparam int EN_READ = 0;
  localparam int EN_SUM  = 1;
  localparam int EN_AVG  = 2;
  localparam int EN_EUC  = 3;
  localparam int EN_MAN  = 4;
  localparam int EN_DOT  = 5;
  localparam int N_OPS   = 6;

endpackage

// File: rtl/rx_cmd_ctrl_if.sv
// Bundle between the UART receiver / core and the receive command controller.
// The master modport is the controller's view; slave is the environment's.
interface rx_cmd_ctrl_if #(
  parameter int ADDR_W = 10
);
  import rx_pkg::*;

  logic              rx_ready;
  logic [7:0]        rx_data;
  logic              proc_busy;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [N_OPS-1:0]  enables;
  logic              load_done;
  logic              busy;
  logic              error;

  modport master (
    input  rx_ready, rx_data, proc_busy,
    output wr_en, wr_sel, wr_addr, wr_data, enables, load_done, busy, error
  );

  modport slave (
    output rx_ready, rx_data, proc_busy,
    input  wr_en, wr_sel, wr_addr, wr_data, enables, load_done, busy, error
  );

endinterface

// File: rtl/rx_cmd_ctrl_decoder.sv
// Purely combinational command byte decode: one-hot operation select plus
// flags telling the controller whether the byte is an operation or a load.
module cmd_decoder
  import rx_pkg::*;
(
  input  logic [7:0]       cmd_byte,
  output logic [N_OPS-1:0] op_onehot,
  output logic             op_valid,
  output logic             is_load,
  output logic             load_sel
);

  always_comb begin
    op_onehot = '0;
    op_valid  = 1'b0;
    is_load   = 1'b0;
    load_sel  = 1'b0;
    case (cmd_byte)
      CMD_LOAD_A: is_load = 1'b1;
      CMD_LOAD_B: begin
        is_load  = 1'b1;
        load_sel = 1'b1;
      end
      CMD_READ: begin op_valid = 1'b1; op_onehot[EN_READ] = 1'b1; end
      CMD_SUM:  begin op_valid = 1'b1; op_onehot[EN_SUM]  = 1'b1; end
      CMD_AVG:  begin op_valid = 1'b1; op_onehot[EN_AVG]  = 1'b1; end
      CMD_EUC:  begin op_valid = 1'b1; op_onehot[EN_EUC]  = 1'b1; end
      CMD_MAN:  begin op_valid = 1'b1; op_onehot[EN_MAN]  = 1'b1; end
      CMD_DOT:  begin op_valid = 1'b1; op_onehot[EN_DOT]  = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/rx_cmd_ctrl.sv
// Receive-side command controller: decodes command bytes, streams vector payloads
// into memory A/B and pulses operation enables. RX_TIMEOUT_EN adds a payload gap timeout.
module rx_cmd_ctrl
  import rx_pkg::*;
#(
  parameter int N_ELEM         = 1024,
  parameter int ADDR_W         = $clog2(N_ELEM),
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic           clk,
  input logic           reset,
  rx_cmd_ctrl_if.master bus
);

  rx_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [N_OPS-1:0]  enables_q, enables_d;
  logic              load_done_q, load_done_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;

  logic [N_OPS-1:0]  op_onehot;
  logic              op_valid;
  logic              is_load;
  logic              load_sel;
  logic              last_elem;
  logic              timeout_hit;

  cmd_decoder u_dec (
    .cmd_byte  (bus.rx_data),
    .op_onehot (op_onehot),
    .op_valid  (op_valid),
    .is_load   (is_load),
    .load_sel  (load_sel)
  );

  assign last_elem = (cnt_q == ADDR_W'(N_ELEM - 1));

`ifdef RX_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap_q, gap_d;

  // An arriving byte beats the limit, so the timeout only fires on an empty cycle
  assign timeout_hit = (state_q == LOAD) && !bus.rx_ready &&
                       (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    gap_d = '0;
    if (state_q == LOAD && !bus.rx_ready && !timeout_hit) begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      enables_q   <= '0;
      load_done_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      wr_sel_q    <= wr_sel_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      enables_q   <= enables_d;
      load_done_q <= load_done_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  // FINISH decodes an incoming byte exactly like IDLE so a command there is not lost
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FINISH: state_d = (bus.rx_ready && is_load) ? LOAD : IDLE;
      LOAD: begin
        if (bus.rx_ready && last_elem) begin
          state_d = FINISH;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // busy stays up through the cycle that carries load_done
  always_comb begin
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    wr_sel_d    = wr_sel_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    enables_d   = '0;
    load_done_d = (state_q == FINISH);
    error_d     = timeout_hit;
    busy_d      = (state_d != IDLE) || (state_q == FINISH);
    if (bus.rx_ready) begin
      if (state_q == LOAD) begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = bus.rx_data;
        if (!last_elem) begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end else if (is_load) begin
        wr_sel_d = load_sel;
        cnt_d    = '0;
      end else if (op_valid && !bus.proc_busy) begin
        enables_d = op_onehot;
      end else begin
        error_d = 1'b1;
      end
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_sel    = wr_sel_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.enables   = enables_q;
  assign bus.load_done = load_done_q;
  assign bus.busy      = busy_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Self-checking bench for rx_cmd_ctrl with N_ELEM=8 and TIMEOUT_CYCLES=50.
// Each vector row is one cycle of input; its expected values are the registered outputs one edge later.
module tb_rx_cmd_ctrl;
  import rx_pkg::*;

  localparam int N_ELEM         = 8;
  localparam int ADDR_W         = 3;
  localparam int TIMEOUT_CYCLES = 50;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rx_cmd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  rx_cmd_ctrl #(
    .N_ELEM         (N_ELEM),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic              wen;
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic [5:0]        en;
    logic              ld;
    logic              busy;
    logic              err;
    logic              chk_addr;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [7:0] din;
    logic       pb;
    exp_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(logic wen, logic sel, int addr, int data, logic [5:0] en,
                              logic ld, logic busy, logic err, logic chk);
    exp_t e;
    e.wen      = wen;
    e.sel      = sel;
    e.addr     = ADDR_W'(addr);
    e.data     = 8'(data);
    e.en       = en;
    e.ld       = ld;
    e.busy     = busy;
    e.err      = err;
    e.chk_addr = chk;
    return e;
  endfunction

  task automatic addVec(logic rst, logic rdy, int din, logic pb, exp_t e);
    vec_t v;
    v.rst = rst;
    v.rdy = rdy;
    v.din = 8'(din);
    v.pb  = pb;
    v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs on the falling edge, then settle just past the rising edge
  task automatic applyStimulus(logic rst, logic rdy, logic [7:0] din, logic pb);
    @(negedge clk);
    reset         = rst;
    bus.rx_ready  = rdy;
    bus.rx_data   = din;
    bus.proc_busy = pb;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(string tag, exp_t e);
    cmp({tag, " wr_en"},     32'(bus.wr_en),     32'(e.wen));
    cmp({tag, " wr_sel"},    32'(bus.wr_sel),    32'(e.sel));
    cmp({tag, " enables"},   32'(bus.enables),   32'(e.en));
    cmp({tag, " load_done"}, 32'(bus.load_done), 32'(e.ld));
    cmp({tag, " busy"},      32'(bus.busy),      32'(e.busy));
    cmp({tag, " error"},     32'(bus.error),     32'(e.err));
    if (e.chk_addr) begin
      cmp({tag, " wr_addr"}, 32'(bus.wr_addr), 32'(e.addr));
      cmp({tag, " wr_data"}, 32'(bus.wr_data), 32'(e.data));
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] b_bytes [8];
    b_bytes = '{8'h05, 8'h08, 8'h01, 8'h03, 8'hFF, 8'h02, 8'h07, 8'h04};

    reset         = 1'b1;
    bus.rx_ready  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.proc_busy = 1'b0;

    // Reset, then load A with 0x10..0x17
    addVec(1, 0, 0, 0, mk(0, 0, 0, 0, 6'b0, 0, 0, 0, 1));
    addVec(0, 1, 8'h01, 0, mk(0, 0, 0, 0, 6'b0, 0, 1, 0, 0));
    for (int i = 0; i < 8; i++) addVec(0, 1, 8'h10 + i, 0, mk(1, 0, i, 8'h10 + i, 6'b0, 0, 1, 0, 1));
    addVec(0, 0, 0, 0, mk(0, 0, 0, 0, 6'b0, 1, 1, 0, 0));
    addVec(0, 0, 0, 0, mk(0, 0, 0, 0, 6'b0, 0, 0, 0, 0));
    // Load B with payload bytes that look like commands
    addVec(0, 1, 8'h02, 0, mk(0, 1, 0, 0, 6'b0, 0, 1, 0, 0));
    for (int i = 0; i < 8; i++) addVec(0, 1, b_bytes[i], 0, mk(1, 1, i, b_bytes[i], 6'b0, 0, 1, 0, 1));
    addVec(0, 0, 0, 0, mk(0, 1, 0, 0, 6'b0, 1, 1, 0, 0));
    addVec(0, 0, 0, 0, mk(0, 1, 0, 0, 6'b0, 0, 0, 0, 0));
    // Operations, busy rejection, illegal bytes, back-to-back commands
    addVec(0, 1, 8'h07, 0, mk(0, 1, 0, 0, 6'b010000, 0, 0, 0, 0));
    addVec(0, 0, 0, 0,     mk(0, 1, 0, 0, 6'b000000, 0, 0, 0, 0));
    addVec(0, 1, 8'h08, 1, mk(0, 1, 0, 0, 6'b000000, 0, 0, 1, 0));
    addVec(0, 0, 0, 0,     mk(0, 1, 0, 0, 6'b000000, 0, 0, 0, 0));
    addVec(0, 1, 8'h3F, 0, mk(0, 1, 0, 0, 6'b000000, 0, 0, 1, 0));
    addVec(0, 1, 8'h04, 0, mk(0, 1, 0, 0, 6'b000010, 0, 0, 0, 0));
    addVec(0, 1, 8'h00, 0, mk(0, 1, 0, 0, 6'b000000, 0, 0, 1, 0));
    addVec(0, 1, 8'h09, 0, mk(0, 1, 0, 0, 6'b000000, 0, 0, 1, 0));
    addVec(0, 1, 8'h03, 0, mk(0, 1, 0, 0, 6'b000001, 0, 0, 0, 0));
    addVec(0, 1, 8'h08, 0, mk(0, 1, 0, 0, 6'b100000, 0, 0, 0, 0));
    addVec(0, 1, 8'h05, 0, mk(0, 1, 0, 0, 6'b000100, 0, 0, 0, 0));
    addVec(0, 1, 8'h06, 0, mk(0, 1, 0, 0, 6'b001000, 0, 0, 0, 0));
    addVec(0, 1, 8'h06, 1, mk(0, 1, 0, 0, 6'b000000, 0, 0, 1, 0));
    addVec(0, 0, 0, 0,     mk(0, 1, 0, 0, 6'b000000, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].din, vecs[i].pb);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    $display("[TB] command arriving in FINISH");
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
      checkOutput($sformatf("finA%0d", i), mk(1, 0, i, 8'hA0 + i, 6'b0, 0, 1, 0, 1));
    end
    applyStimulus(1'b0, 1'b1, 8'h06, 1'b0);
    checkOutput("finCmd", mk(0, 0, 0, 0, 6'b001000, 1, 1, 0, 0));
    idleCycle();
    checkOutput("finIdle", mk(0, 0, 0, 0, 6'b0, 0, 0, 0, 0));

    $display("[TB] reset in the middle of a load");
    applyStimulus(1'b0, 1'b1, 8'h02, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("midRst", mk(0, 0, 0, 0, 6'b0, 0, 0, 0, 1));
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0);
    checkOutput("rstLoadCmd", mk(0, 0, 0, 0, 6'b0, 0, 1, 0, 0));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'hB0 + i), 1'b0);
      checkOutput($sformatf("rstLoad%0d", i), mk(1, 0, i, 8'hB0 + i, 6'b0, 0, 1, 0, 1));
    end
    idleCycle();
    checkOutput("rstLoadDone", mk(0, 0, 0, 0, 6'b0, 1, 1, 0, 0));
    idleCycle();

`ifdef RX_TIMEOUT_EN
    $display("[TB] payload gap timeout");
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'(8'hD0 + i), 1'b0);
    for (int k = 1; k < TIMEOUT_CYCLES; k++) begin
      idleCycle();
      cmp($sformatf("gap%0d error", k), 32'(bus.error), 32'd0);
      cmp($sformatf("gap%0d busy", k), 32'(bus.busy), 32'd1);
    end
    idleCycle();
    cmp("timeout error", 32'(bus.error), 32'd1);
    cmp("timeout busy", 32'(bus.busy), 32'd0);
    cmp("timeout load_done", 32'(bus.load_done), 32'd0);
    idleCycle();
    checkOutput("afterTimeout", mk(0, 0, 0, 0, 6'b0, 0, 0, 0, 0));

    $display("[TB] byte arriving on the timeout limit");
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'(8'hE0 + i), 1'b0);
    for (int k = 1; k < TIMEOUT_CYCLES; k++) idleCycle();
    applyStimulus(1'b0, 1'b1, 8'hE3, 1'b0);
    checkOutput("limitByte", mk(1, 0, 3, 8'hE3, 6'b0, 0, 1, 0, 1));
    for (int i = 4; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'hE0 + i), 1'b0);
      checkOutput($sformatf("limitLoad%0d", i), mk(1, 0, i, 8'hE0 + i, 6'b0, 0, 1, 0, 1));
    end
    idleCycle();
    checkOutput("limitDone", mk(0, 0, 0, 0, 6'b0, 1, 1, 0, 0));
    idleCycle();
`else
    $display("[TB] long payload gap without timeout");
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'(8'hD0 + i), 1'b0);
    for (int k = 1; k <= 60; k++) begin
      idleCycle();
      cmp($sformatf("gap%0d error", k), 32'(bus.error), 32'd0);
      cmp($sformatf("gap%0d busy", k), 32'(bus.busy), 32'd1);
    end
    for (int i = 3; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'hD0 + i), 1'b0);
      checkOutput($sformatf("gapLoad%0d", i), mk(1, 0, i, 8'hD0 + i, 6'b0, 0, 1, 0, 1));
    end
    idleCycle();
    checkOutput("gapDone", mk(0, 0, 0, 0, 6'b0, 1, 1, 0, 0));
    idleCycle();
`endif

    checkOutput("final", mk(0, 0, 0, 0, 6'b0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_cmd_ctrl.md
# rx_cmd_ctrl

Receive-side command controller for the UART link. It consumes bytes from the UART receiver, decodes a one-byte command, streams vector payload bytes into the vector memories A or B, and issues one-cycle operation enables to the processing core. The processing core's output is returned by the transmit path. The block mirrors the transmit controller's byte-level protocol in the opposite direction.

## Interface
- `N_ELEM`, default 1024: elements per vector, one byte per element.
- `ADDR_W`, default `$clog2(N_ELEM)`: memory address width.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle clock cycles allowed between payload bytes.
- `clk` in 1: system clock. This is the only clock.
- `reset` in 1: synchronous, active-high reset.
- `rx_ready` in 1: one-cycle pulse from the UART receiver; `rx_data` is valid in the same cycle.
- `rx_data` in 8: received byte.
- `proc_busy` in 1: the core or transmit path is busy and cannot start an operation.
- `wr_en` out 1: memory write strobe.
- `wr_sel` out 1: memory select, 0 = vector A, 1 = vector B.
- `wr_addr` out ADDR_W: element address.
- `wr_data` out 8: element value.
- `enables` out 6: one-hot operation pulse, bit order {dot, man, euc, avg, sum, read}.
- `load_done` out 1: one-cycle pulse when the last element of a vector has been written.
- `busy` out 1: high whenever the state is not IDLE.
- `error` out 1: one-cycle pulse on a rejected command or a timeout.

## Operation
- Command bytes:
  - 0x01: load vector A.
  - 0x02: load vector B.
  - 0x03: read.
  - 0x04: sum.
  - 0x05: avg.
  - 0x06: euc.
  - 0x07: man.
  - 0x08: dot.
- States:
  - IDLE: waits for a command byte.
  - LOAD: accepts payload bytes.
  - FINISH: lasts one cycle and emits `load_done`.
- IDLE behaviour on `rx_ready`:
  - 0x01 or 0x02: latch `wr_sel` (0 for 0x01, 1 for 0x02), clear the element counter, go to LOAD.
  - 0x03..0x08 with `proc_busy`=0: pulse the matching `enables` bit; stay in IDLE.
  - 0x03..0x08 with `proc_busy`=1: drop the command, pulse `error`.
  - Any other value: pulse `error`, stay in IDLE.
- LOAD behaviour on `rx_ready`:
  - Write the byte (`wr_en`=1, `wr_addr`=counter, `wr_data`=byte), then increment the counter.
  - When the written address is N_ELEM-1, go to FINISH.
  - Payload bytes are never decoded as commands, including values 0x01..0x08.
- FINISH: pulse `load_done`, return to IDLE.
- Counter width is ADDR_W. It never wraps inside LOAD because FINISH is entered at N_ELEM-1.
- Reset at any point, including mid-load:
  - State returns to IDLE.
  - All outputs go to 0: `wr_en`, `wr_sel`, `wr_addr`, `wr_data`, `enables`, `load_done`, `busy`, `error`.
  - Memory contents already written are not cleared.

## Timing
- Every output is registered.
- `wr_en`, `wr_addr` and `wr_data` assert in the cycle after the `rx_ready` that carried the byte.
- An `enables` pulse asserts one cycle after `rx_ready` of the command byte and is exactly one cycle wide.
- `load_done` asserts two cycles after `rx_ready` of the last byte, i.e. one cycle after its `wr_en`.
- `busy` rises in the cycle after a load command is received and falls in the cycle after `load_done`.
- `rx_ready` arriving during FINISH is treated as a new command in IDLE: the byte is latched, not lost.
- Back-to-back `rx_ready` pulses on consecutive cycles are all accepted.
- `proc_busy` is sampled in the same cycle as `rx_ready`.

## Configuration
- Macro `RX_TIMEOUT_EN`.
- Defined:
  - A gap counter runs in LOAD and clears on every accepted byte.
  - If it reaches TIMEOUT_CYCLES-1 without a byte, the block pulses `error`, goes to IDLE and does not emit `load_done`.
  - If `rx_ready` arrives in the same cycle the counter reaches its limit, the byte wins: it is written and the counter clears.
- Undefined:
  - There is no gap counter; LOAD waits indefinitely.
  - `error` is driven only by rejected commands.

## Structure
- Shared package `rx_pkg` contains:
  - the command byte `localparam`s (CMD_LOAD_A .. CMD_DOT);
  - the state enum `rx_state_t` {IDLE, LOAD, FINISH};
  - the enable bit indices, matching the transmit controller's {dot, man, euc, avg, sum, read}.
- Sub-module `cmd_decoder`: combinational byte-to-one-hot decode plus valid/load flags. The FSM and counters stay in `rx_cmd_ctrl`.

## Test plan
- All tests use N_ELEM=8 and TIMEOUT_CYCLES=50.
- Reset, then 0x01 followed by bytes 0x10..0x17 → eight `wr_en` pulses with `wr_sel`=0, addresses 0..7 and data 0x10..0x17; `load_done` two cycles after the last `rx_ready`; `busy` low afterwards.
- 0x02 followed by 8 bytes including 0x05 and 0x08 → all 8 bytes written to B (`wr_sel`=1); no `enables` pulse.
- 0x07 with `proc_busy`=0 → `enables`=6'b010000 for exactly one cycle. 0x08 with `proc_busy`=1 → `enables` stays 0 and `error` pulses once.
- Byte 0x3F in IDLE → `error` pulse, state remains IDLE; a following 0x04 → `enables`=6'b000010.
- With `RX_TIMEOUT_EN`: 0x01, 3 bytes, then 50 idle cycles → `error` pulse, no `load_done`, `busy` low. A byte arriving exactly at cycle 49 is written instead.
- `reset` asserted after 4 of 8 payload bytes → all outputs 0; the next 0x01 starts again at address 0.
